// File: rtl/note_detector_if.sv
// Signal bundle for the note detector: raw tone input plus the recovered note fields.
interface note_detector_if;
   logic        tone_in;
   logic [7:0]  fullnote;
   logic [2:0]  octave;
   logic [3:0]  note;
   logic        note_valid;
   logic        new_note;
   logic [19:0] period;

   modport master (input tone_in, output fullnote, octave, note, note_valid, new_note, period);
   modport slave  (output tone_in, input fullnote, octave, note, note_valid, new_note, period);
endinterface

// File: rtl/note_detector.sv
// Measures the period of tone_in in generator ticks and recovers octave*12+note.
// Define NOTE_DETECT_STABLE_EN to require two agreeing results before outputs move.
module note_detector #(
   parameter int TICK_DIV   = 4,
   parameter int MAX_OCTAVE = 5,
   parameter int TIMEOUT    = 524288
) (
   input  logic            clk,
   input  logic            RESET,
   note_detector_if.master bus
);

   localparam int          DIV_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [19:0] SLOW_LIMIT = 20'd270336;
   localparam logic [19:0] NORM_LIMIT = 20'd135168;
   localparam logic [19:0] TICK_MAX   = '1;

   typedef enum logic [1:0] {IDLE, MEASURE, NORM, CLASS} state_t;

   typedef struct packed {
      logic       valid;
      logic [2:0] octave;
      logic [3:0] note;
   } result_t;

   state_t           state, state_nxt;
   logic [2:0]       sync;
   logic             rise;
   logic [DIV_W-1:0] div_cnt;
   logic             tick;
   logic [19:0]      tick_cnt, tick_cnt_nxt;
   logic [19:0]      sh, sh_nxt;
   logic [2:0]       k, k_nxt;
   logic [19:0]      period_q, period_nxt;
   logic             res_load, res_clear;
   result_t          res_new, res_cur, commit;
   logic             commit_en;
   logic [7:0]       fullnote_q, fn_nxt;
   logic             new_note_q;

   function automatic logic [3:0] classify(input logic [10:0] q);
      if      (q >= 11'd497) return 4'd0;
      else if (q >= 11'd469) return 4'd1;
      else if (q >= 11'd443) return 4'd2;
      else if (q >= 11'd418) return 4'd3;
      else if (q >= 11'd395) return 4'd4;
      else if (q >= 11'd373) return 4'd5;
      else if (q >= 11'd352) return 4'd6;
      else if (q >= 11'd332) return 4'd7;
      else if (q >= 11'd313) return 4'd8;
      else if (q >= 11'd295) return 4'd9;
      else if (q >= 11'd279) return 4'd10;
      else                   return 4'd11;
   endfunction

   // sync[1] is the second synchroniser flop, sync[2] its one-cycle history
   assign rise = sync[1] & ~sync[2];
   assign tick = (div_cnt == DIV_W'(TICK_DIV - 1));

   always_comb begin
      // NOTE: every output of this block gets a default first so no path infers a latch.
      state_nxt    = state;
      k_nxt        = k;
      sh_nxt       = sh;
      period_nxt   = period_q;
      tick_cnt_nxt = (tick && tick_cnt != TICK_MAX) ? tick_cnt + 20'd1 : tick_cnt;
      res_load     = 1'b0;
      res_clear    = 1'b0;
      res_new      = '0;
      case (state)
         IDLE: begin
            if (rise) begin
               tick_cnt_nxt = {19'd0, tick};
               state_nxt    = MEASURE;
            end
         end
         MEASURE: begin
            if (rise) begin
               period_nxt   = tick_cnt;
               sh_nxt       = tick_cnt;
               tick_cnt_nxt = {19'd0, tick};
               k_nxt        = '0;
               if (tick_cnt >= SLOW_LIMIT) res_load  = 1'b1;
               else                        state_nxt = NORM;
            end else if (tick_cnt >= 20'(TIMEOUT)) begin
               res_clear = 1'b1;
               state_nxt = IDLE;
            end
         end
         NORM: begin
            if (sh >= NORM_LIMIT) begin
               state_nxt = CLASS;
            end else if (k == 3'(MAX_OCTAVE)) begin
               res_load  = 1'b1;
               state_nxt = MEASURE;
            end else begin
               sh_nxt = {sh[18:0], 1'b0};
               k_nxt  = k + 3'd1;
            end
         end
         CLASS: begin
            res_load  = 1'b1;
            res_new   = '{valid: 1'b1, octave: k, note: classify(sh[19:9])};
            state_nxt = MEASURE;
         end
         default: state_nxt = IDLE;
      endcase
   end

`ifdef NOTE_DETECT_STABLE_EN
   result_t pend, pend_nxt;
   logic    pend_set, pend_set_nxt;

   always_comb begin
      pend_nxt     = pend;
      pend_set_nxt = pend_set;
      commit       = res_new;
      commit_en    = 1'b0;
      if (res_clear) begin
         commit       = '0;
         commit_en    = 1'b1;
         pend_set_nxt = 1'b0;
      end else if (res_load) begin
         commit_en    = pend_set && (pend == res_new);
         pend_nxt     = res_new;
         pend_set_nxt = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge RESET) begin
      if (!RESET) begin
         pend     <= '0;
         pend_set <= 1'b0;
      end else begin
         pend     <= pend_nxt;
         pend_set <= pend_set_nxt;
      end
   end
`else
   always_comb begin
      commit    = res_clear ? '0 : res_new;
      commit_en = res_load | res_clear;
   end
`endif

   assign fn_nxt = {2'b00, commit.octave, 3'b000} + {3'b000, commit.octave, 2'b00}
                 + {4'b0000, commit.note};

   always_ff @(posedge clk or negedge RESET) begin
      if (!RESET) begin
         state    <= IDLE;
         sync     <= '0;
         div_cnt  <= '0;
         tick_cnt <= '0;
         sh       <= '0;
         k        <= '0;
         period_q <= '0;
      end else begin
         // NOTE: non-blocking throughout so every flop samples pre-edge values.
         state    <= state_nxt;
         sync     <= {sync[1:0], bus.tone_in};
         div_cnt  <= tick ? '0 : div_cnt + 1'b1;
         tick_cnt <= tick_cnt_nxt;
         sh       <= sh_nxt;
         k        <= k_nxt;
         period_q <= period_nxt;
      end
   end

   always_ff @(posedge clk or negedge RESET) begin
      if (!RESET) begin
         res_cur    <= '0;
         fullnote_q <= '0;
         new_note_q <= 1'b0;
      end else begin
         new_note_q <= 1'b0;
         if (commit_en) begin
            res_cur    <= commit;
            fullnote_q <= fn_nxt;
            new_note_q <= {commit.valid, fn_nxt} != {res_cur.valid, fullnote_q};
         end
      end
   end

   assign bus.fullnote   = fullnote_q;
   assign bus.octave     = res_cur.octave;
   assign bus.note       = res_cur.note;
   assign bus.note_valid = res_cur.valid;
   assign bus.new_note   = new_note_q;
   assign bus.period     = period_q;

endmodule

// File: tb/tb_note_detector.sv
// Self-checking bench for note_detector: tone periods are replayed against a
// period-to-note reference model; honours NOTE_DETECT_STABLE_EN when defined.
module tb_note_detector;

   localparam int TMO = 8500;
   localparam int CHK = 12;

   logic clk = 1'b0;
   logic RESET;
   always #5 clk = ~clk;

   note_detector_if bus ();
   note_detector_if bus4 ();
   assign bus4.tone_in = bus.tone_in;

   note_detector #(.TICK_DIV(1), .MAX_OCTAVE(5), .TIMEOUT(TMO)) dut (
      .clk(clk), .RESET(RESET), .bus(bus)
   );
   note_detector dut4 (.clk(clk), .RESET(RESET), .bus(bus4));

   int checks = 0;
   int errors = 0;
   int pulses = 0;
   int exp_pulses = 0;

   int thr[11] = '{497, 469, 443, 418, 395, 373, 352, 332, 313, 295, 279};
   bit armed = 1'b0, armed4 = 1'b0, chk4 = 1'b0, pend_set = 1'b0;
   int cur_code = -1, pend_code = -1;
   int last_len = 0, exp_period = 0, exp_p4 = 0, exp_lat = 0;
   int c_now = 0, fall_at = 0;

   always @(negedge clk) if (bus.new_note === 1'b1) pulses++;

   // Period in ticks -> code (-1 = invalid) and the clk edge after the input
   // rise at which the outputs take the new value.
   function automatic void ref_eval(input int p, output int code, output int lat);
      int k, q, n;
      if (p >= 270336) begin code = -1; lat = 3; return; end
      k = 0;
      while (k < 5 && (p << k) < 135168) k++;
      if ((p << k) < 135168) begin code = -1; lat = 9; return; end
      q = (p << k) >> 9;
      n = 11;
      for (int i = 10; i >= 0; i--) if (q >= thr[i]) n = i;
      code = k * 12 + n;
      lat  = 5 + k;
   endfunction

   function automatic logic [15:0] exp_vec();
      if (cur_code < 0) return 16'h0;
      return {1'b1, 8'(cur_code), 3'(cur_code / 12), 4'(cur_code % 12)};
   endfunction

   task automatic show(input int code);
      if (code != cur_code) exp_pulses++;
      cur_code = code;
   endtask

   task automatic apply_result(input int code);
`ifdef NOTE_DETECT_STABLE_EN
      if (pend_set && pend_code == code) show(code);
      pend_code = code;
      pend_set  = 1'b1;
`else
      show(code);
`endif
   endtask

   task automatic model_edge(input int len);
      int code;
      bus.tone_in = 1'b1;
      c_now   = 0;
      fall_at = len / 2;
      chk4    = armed4 && (last_len % 4 == 0);
      exp_p4  = last_len / 4;
      exp_lat = 3;
      if (armed) begin
         exp_period = last_len;
         ref_eval(last_len, code, exp_lat);
         apply_result(code);
      end
      armed    = 1'b1;
      armed4   = 1'b1;
      last_len = len;
   endtask

   task automatic wait_to(input int c);
      while (c_now < c) begin
         @(posedge clk);
         #1;
         c_now++;
         if (c_now == fall_at) bus.tone_in = 1'b0;
      end
   endtask

   task automatic test_reset();
      RESET = 1'b0;
      bus.tone_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({bus.note_valid, bus.fullnote, bus.octave, bus.note} !== 16'h0)
         $display("FAIL reset_fields: got %h expected 0000", {bus.note_valid, bus.fullnote, bus.octave, bus.note});
      checks++;
      if ({bus.period, bus.new_note} !== 21'h0)
         $display("FAIL reset_period: got period %0d new_note %b expected 0/0", bus.period, bus.new_note);
      RESET = 1'b1;
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic test_too_fast();
      for (int i = 0; i < 4; i++) begin
         model_edge(100);
         wait_to(CHK);
         checks++;
         if ({bus.note_valid, bus.fullnote, bus.octave, bus.note} !== exp_vec()) begin
            errors++;
            $display("FAIL too_fast_fields[%0d]: got %h expected %h", i, {bus.note_valid, bus.fullnote, bus.octave, bus.note}, exp_vec());
         end
         checks++;
         if (bus.period !== 20'(exp_period) || pulses != exp_pulses) begin
            errors++;
            $display("FAIL too_fast_period[%0d]: got %0d/%0d pulses expected %0d/%0d", i, bus.period, pulses, exp_period, exp_pulses);
         end
         if (chk4) begin
            checks++;
            if (bus4.period !== 20'(exp_p4)) begin
               errors++;
               $display("FAIL prescaler_period[%0d]: got %0d expected %0d", i, bus4.period, exp_p4);
            end
         end
         wait_to(100);
      end
   endtask

   task automatic test_boundaries();
      int lens[4] = '{4223, 4224, 8448, 4300};
      logic [15:0] old;
      for (int i = 0; i < 4; i++) begin
         old = exp_vec();
         model_edge(lens[i]);
         wait_to(exp_lat - 1);
         checks++;
         if ({bus.note_valid, bus.fullnote, bus.octave, bus.note} !== old) begin
            errors++;
            $display("FAIL bound_early[%0d]: got %h expected %h", i, {bus.note_valid, bus.fullnote, bus.octave, bus.note}, old);
         end
         wait_to(exp_lat);
         checks++;
         if ({bus.note_valid, bus.fullnote, bus.octave, bus.note} !== exp_vec()) begin
            errors++;
            $display("FAIL bound_latency[%0d]: got %h expected %h", i, {bus.note_valid, bus.fullnote, bus.octave, bus.note}, exp_vec());
         end
         wait_to(CHK);
         checks++;
         if (bus.period !== 20'(exp_period) || pulses != exp_pulses) begin
            errors++;
            $display("FAIL bound_period[%0d]: got %0d/%0d pulses expected %0d/%0d", i, bus.period, pulses, exp_period, exp_pulses);
         end
         wait_to(lens[i]);
      end
   endtask

   task automatic test_random();
      int len;
      for (int i = 0; i < 2; i++) begin
         len = (4224 + $urandom_range(0, 2276)) & ~32'd3;
         for (int j = 0; j < 2; j++) begin
            model_edge(len);
            wait_to(CHK);
            checks++;
            if ({bus.note_valid, bus.fullnote, bus.octave, bus.note} !== exp_vec()) begin
               errors++;
               $display("FAIL random_fields[%0d.%0d]: got %h expected %h", i, j, {bus.note_valid, bus.fullnote, bus.octave, bus.note}, exp_vec());
            end
            checks++;
            if (bus.period !== 20'(exp_period) || pulses != exp_pulses) begin
               errors++;
               $display("FAIL random_period[%0d.%0d]: got %0d/%0d pulses expected %0d/%0d", i, j, bus.period, pulses, exp_period, exp_pulses);
            end
            if (chk4) begin
               checks++;
               if (bus4.period !== 20'(exp_p4)) begin
                  errors++;
                  $display("FAIL random_prescaler[%0d.%0d]: got %0d expected %0d", i, j, bus4.period, exp_p4);
               end
            end
            wait_to(len);
         end
      end
   endtask

   task automatic test_glitch();
      int lens[4] = '{5000, 5000, 4400, 5000};
      for (int i = 0; i < 4; i++) begin
         model_edge(lens[i]);
         wait_to(CHK);
         checks++;
         if ({bus.note_valid, bus.fullnote, bus.octave, bus.note} !== exp_vec() || pulses != exp_pulses) begin
            errors++;
            $display("FAIL glitch[%0d]: got %h/%0d pulses expected %h/%0d", i, {bus.note_valid, bus.fullnote, bus.octave, bus.note}, pulses, exp_vec(), exp_pulses);
         end
         wait_to(lens[i]);
      end
   endtask

   task automatic test_timeout();
      model_edge(8600);
      wait_to(2 + TMO);
      checks++;
      if ({bus.note_valid, bus.fullnote, bus.octave, bus.note} !== exp_vec()) begin
         errors++;
         $display("FAIL timeout_early: got %h expected %h", {bus.note_valid, bus.fullnote, bus.octave, bus.note}, exp_vec());
      end
      show(-1);
      pend_set = 1'b0;
      armed    = 1'b0;
      wait_to(3 + TMO);
      checks++;
      if ({bus.note_valid, bus.fullnote, bus.octave, bus.note} !== exp_vec()) begin
         errors++;
         $display("FAIL timeout_clear: got %h expected %h", {bus.note_valid, bus.fullnote, bus.octave, bus.note}, exp_vec());
      end
      wait_to(6 + TMO);
      checks++;
      if (pulses != exp_pulses || bus.period !== 20'(exp_period)) begin
         errors++;
         $display("FAIL timeout_pulse: got %0d pulses period %0d expected %0d/%0d", pulses, bus.period, exp_pulses, exp_period);
      end
      wait_to(8600);
   endtask

   task automatic test_rearm_reset();
      for (int i = 0; i < 3; i++) begin
         model_edge(4500);
         wait_to(CHK);
         checks++;
         if ({bus.note_valid, bus.fullnote, bus.octave, bus.note} !== exp_vec() || pulses != exp_pulses) begin
            errors++;
            $display("FAIL rearm[%0d]: got %h/%0d pulses expected %h/%0d", i, {bus.note_valid, bus.fullnote, bus.octave, bus.note}, pulses, exp_vec(), exp_pulses);
         end
         checks++;
         if (bus.period !== 20'(exp_period)) begin
            errors++;
            $display("FAIL rearm_period[%0d]: got %0d expected %0d", i, bus.period, exp_period);
         end
         if (i == 1) begin
            wait_to(2350);
            #2 RESET = 1'b0;
            armed = 1'b0; armed4 = 1'b0; pend_set = 1'b0;
            cur_code = -1; exp_period = 0;
            #1;
            checks++;
            if ({bus.note_valid, bus.fullnote, bus.octave, bus.note, bus.period, bus.new_note} !== 37'h0) begin
               errors++;
               $display("FAIL reset_mid: got %h/%0d expected all zero", {bus.note_valid, bus.fullnote, bus.octave, bus.note}, bus.period);
            end
            wait_to(2355);
            RESET = 1'b1;
         end
         if (i < 2) wait_to(4500);
      end
   endtask

   initial begin
      test_reset();
      test_too_fast();
      test_boundaries();
      test_random();
      test_glitch();
      test_timeout();
      test_rearm_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/note_detector.md
Name: note_detector

Overview:
- Receive-side counterpart of the ROM-driven tone generator: measures the period of an incoming square wave and recovers the note code that produced it.
- Output encoding matches the generator: fullnote = octave*12 + note, with note index 0=A, 1=Bb, 2=B, 3=C, 4=Db, 5=D, 6=Eb, 7=E, 8=F, 9=Gb, 10=G, 11=Ab.
- Sits between a board input pin (another board's speaker line, or a comparator) and the 7-segment note display and downstream logic.

Parameters:
- TICK_DIV, 4, clk cycles per measurement tick (100 MHz / 4 = 25 MHz, the generator's time base).
- MAX_OCTAVE, 5, highest octave accepted; any higher frequency is out of range.
- TIMEOUT, 524288, ticks with no rising edge before the input is declared silent.

Ports:
- clk  input  1  100 MHz system clock.
- RESET  input  1  asynchronous, active-low reset.
- tone_in  input  1  asynchronous square wave; needs synchronising.
- fullnote  output  8  octave*12+note; 0 when not valid.
- octave  output  3  recovered octave.
- note  output  4  recovered note index, 0..11.
- note_valid  output  1  high while a legal note is detected.
- new_note  output  1  one-cycle pulse when {note_valid, fullnote} changes.
- period  output  20  last measured period in ticks.

Behaviour:
- Reset (RESET low, asynchronous): all outputs 0, state IDLE, counters and synchroniser flops 0.
- Input path: 2-flop synchroniser, then a rising-edge detect on the synchronised signal (edge cycle E).
- Tick prescaler: free-running mod TICK_DIV; tick_cnt (20 bits, saturating) increments once per tick.
- State IDLE:
  - On a rising edge: clear tick_cnt, go to MEASURE.
  - The first edge produces no result.
- State MEASURE:
  - On a rising edge: latch tick_cnt into period and shift register sh, clear tick_cnt (measurement of the next period starts the same cycle), set k=0, go to NORM.
  - If tick_cnt reaches TIMEOUT: set note_valid=0 and fullnote/octave/note=0, pulse new_note if note_valid was 1, go to IDLE.
- Range check at latch: if period >= 270336 (528*512), the sample is too slow. The result is invalid: note_valid=0, fields 0. Skip NORM and CLASS.
- State NORM, one cycle per step:
  - If sh >= 135168 (264*512), go to CLASS.
  - Else if k == MAX_OCTAVE, the sample is invalid (too fast) and the block returns to MEASURE.
  - Else sh <= sh<<1 and k <= k+1.
- State CLASS (single cycle):
  - q = sh>>9. Then octave=k. Thresholds on q select the note:
  - q>=497 A; >=469 Bb; >=443 B; >=418 C; >=395 Db; >=373 D; >=352 Eb; >=332 E; >=313 F; >=295 Gb; >=279 G; else Ab.
  - Register the outputs, then return to MEASURE.
- Latency: outputs change at the end of cycle E+k+2.
- Edges arriving during NORM/CLASS: tick_cnt still counts. A further edge in that window is ignored; legal periods are far longer than the window.
- Width rules:
  - sh is 20 bits; it never overflows given the range check.
  - fullnote = {octave,3'b0}+{octave,2'b0}+note, computed 8 bits wide.
- new_note: asserted for exactly one clk cycle whenever the registered {note_valid, fullnote} differs from its previous value. Not asserted when an identical result is re-registered.
- RESET asserted mid-measurement or mid-NORM: immediate return to IDLE with outputs 0. No partial result is emitted.

Optional Feature:
- Macro: NOTE_DETECT_STABLE_EN.
- Defined: a classification is held as pending and outputs update only when two consecutive classifications (or two consecutive invalid results) agree. A disagreeing result replaces the pending value. Timeout bypasses the filter.
- Undefined: every classification updates the outputs immediately.

Test Plan:
- Reset, then square wave with period 61824 ticks (247296 clk): from the second edge, fullnote=25, octave=2, note=1, note_valid=1, one new_note pulse. Repeated periods produce no further pulses.
- Period 46336 ticks, then switch to 82688 ticks: fullnote 30 (oct 2, note 6), then fullnote 20 (oct 1, note 8); one new_note pulse per change.
- Period 262144 ticks: fullnote=0 (A, octave 0), note_valid=1. Period 300000 ticks: note_valid=0, fullnote=0.
- Period 100 ticks (too fast): note_valid stays 0 after the NORM limit at k=5.
- Stop toggling after a valid note: exactly TIMEOUT ticks after the last edge, note_valid drops, fields become 0, and new_note pulses once. A subsequent edge only re-arms; the result follows one period later.
- RESET pulled low midway through a period: outputs 0 asynchronously, no result for that period. With NOTE_DETECT_STABLE_EN, a single odd period between two 61824-tick runs leaves fullnote=25 unchanged.
